// File: rtl/audio_tone_scheduler.sv
`timescale 1ns/1ps
// Stereo tone sequencer: shares one sine ROM between two phase
// accumulators and presents attenuated sample pairs downstream.
module audio_tone_scheduler #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_audio,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  sample_tick,
   input  logic [ADDR_WIDTH-1:0] step_l,
   input  logic [ADDR_WIDTH-1:0] step_r,
   input  logic [3:0]            atten_l,
   input  logic [3:0]            atten_r,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_left,
   output logic [DATA_WIDTH-1:0] out_right,
   output logic                  overrun
);

   typedef enum logic [2:0] {
      IDLE,
      RD_L,
      RD_R,
      CAP_R,
      PRESENT
   } state_t;

   state_t state, state_nxt;

   logic                         start;
   logic [ADDR_WIDTH-1:0]        phase_l, phase_r;
   logic [ADDR_WIDTH-1:0]        stp_l, stp_r;
   logic [3:0]                   atn_l, atn_r;
   logic signed [DATA_WIDTH-1:0] rd_s, sh_l, sh_r, cap_l;

   assign start = sample_tick && enable;
   assign rd_s  = rom_data;
   assign sh_l  = rd_s >>> atn_l;
   assign sh_r  = rd_s >>> atn_r;

   assign out_valid = (state == PRESENT);

   always_ff @(posedge clk_audio) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RD_L;
         RD_L:    state_nxt = RD_R;
         RD_R:    state_nxt = CAP_R;
         CAP_R:   state_nxt = PRESENT;
         PRESENT: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_audio) begin
      if (reset) begin
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         phase_l   <= '0;
         phase_r   <= '0;
         stp_l     <= '0;
         stp_r     <= '0;
         atn_l     <= '0;
         atn_r     <= '0;
         cap_l     <= '0;
         out_left  <= '0;
         out_right <= '0;
         overrun   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            stp_l <= step_l;
            stp_r <= step_r;
            atn_l <= atten_l;
            atn_r <= atten_r;
         end

         // Address is staged one cycle ahead so the ROM sees a registered strobe.
         rom_en <= (state_nxt == RD_L) || (state_nxt == RD_R);
         if (state_nxt == RD_L)      rom_addr <= phase_l;
         else if (state_nxt == RD_R) rom_addr <= phase_r;
         else                        rom_addr <= '0;

         if (state == RD_R) begin
            cap_l   <= sh_l;
            phase_l <= phase_l + stp_l;
         end

         // Both outputs move together on entry to PRESENT.
         if (state == CAP_R) begin
            out_left  <= cap_l;
            out_right <= sh_r;
            phase_r   <= phase_r + stp_r;
         end

         if (sample_tick && state != IDLE) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_tone_scheduler.sv
`timescale 1ns/1ps
// Randomised and directed bench for audio_tone_scheduler with a
// frame-level reference model and a behavioural ROM.
module tb_audio_tone_scheduler;

   localparam int AW   = 10;
   localparam int DW   = 16;
   localparam int SIZE = 1 << AW;

   logic          clk_audio = 1'b0;
   logic          reset;
   logic          enable;
   logic          sample_tick;
   logic [AW-1:0] step_l, step_r;
   logic [3:0]    atten_l, atten_r;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_left, out_right;
   logic          overrun;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            phl, phr;
   int            rom_mode;
   logic [DW-1:0] rom_const;

   always #5 clk_audio = ~clk_audio;

   audio_tone_scheduler #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk_audio  (clk_audio),
      .reset      (reset),
      .enable     (enable),
      .sample_tick(sample_tick),
      .step_l     (step_l),
      .step_r     (step_r),
      .atten_l    (atten_l),
      .atten_r    (atten_r),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_left   (out_left),
      .out_right  (out_right),
      .overrun    (overrun)
   );

   function automatic logic [DW-1:0] rom_fn(input int a);
      case (rom_mode)
         0:       return DW'(a);
         1:       return rom_const;
         default: return DW'((a * 40503) ^ 23130);
      endcase
   endfunction

   always @(posedge clk_audio)
      if (rom_en) rom_data <= rom_fn(int'(rom_addr));

   // Signed value divided by 2**a, rounded toward minus infinity.
   function automatic logic [DW-1:0] atten_fn(input logic [DW-1:0] raw,
                                              input int a);
      int v, d, q;
      v = int'(raw);
      if (v >= 32768) v -= 65536;
      d = 1 << a;
      q = v / d;
      if (v < 0 && (v % d) != 0) q--;
      return DW'(q);
   endfunction

   task automatic do_reset();
      @(negedge clk_audio);
      reset       = 1'b1;
      sample_tick = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk_audio);
      reset = 1'b0;
      phl   = 0;
      phr   = 0;
   endtask

   task automatic do_frame(input logic [AW-1:0] sl, sr,
                           input logic [3:0] al, ar,
                           input int stall,
                           output logic [DW-1:0] ol, orr,
                           output int vlat,
                           output logic [AW-1:0] pa_l, pa_r,
                           output bit held);
      @(negedge clk_audio);
      step_l      = sl;
      step_r      = sr;
      atten_l     = al;
      atten_r     = ar;
      enable      = 1'b1;
      sample_tick = 1'b1;
      out_ready   = (stall == 0);
      @(negedge clk_audio);
      sample_tick = 1'b0;
      step_l      = AW'($urandom);
      atten_l     = 4'($urandom);
      pa_l        = rom_addr;
      @(negedge clk_audio);
      step_r  = AW'($urandom);
      atten_r = 4'($urandom);
      pa_r    = rom_addr;
      vlat    = 2;
      while (!out_valid && vlat < 16) begin
         @(negedge clk_audio);
         vlat++;
      end
      ol   = out_left;
      orr  = out_right;
      held = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_audio);
         if (!out_valid || out_left !== ol || out_right !== orr) held = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk_audio);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_audio);
         enable      = 1'($urandom);
         sample_tick = 1'($urandom);
         out_ready   = 1'($urandom);
         step_l      = AW'($urandom);
         step_r      = AW'($urandom);
         atten_l     = 4'($urandom);
         atten_r     = 4'($urandom);
      end
      @(negedge clk_audio);
      reset       = 1'b0;
      sample_tick = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk_audio);
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_chk++;
      if (rom_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rom_en: got %b expected 0", rom_en);
      end
      n_chk++;
      if (rom_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
      end
      n_chk++;
      if (out_left !== '0 || out_right !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h/%h expected 0/0",
                  out_left, out_right);
      end
      n_chk++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_overrun: got %b expected 0", overrun);
      end
      phl = 0;
      phr = 0;
   endtask

   task automatic test_identity();
      logic [DW-1:0] ol, orr;
      logic [AW-1:0] pa_l, pa_r;
      int            vlat;
      bit            held;
      rom_mode = 0;
      for (int f = 1; f <= 130; f++) begin
         do_frame(8, 16, 0, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
         n_chk++;
         if (ol !== DW'(phl) || orr !== DW'(phr)) begin
            n_fail++;
            $display("FAIL ident_pair f%0d: got %0d,%0d expected %0d,%0d",
                     f, ol, orr, phl, phr);
         end
         n_chk++;
         if (vlat !== 4) begin
            n_fail++;
            $display("FAIL ident_latency f%0d: got %0d expected 4", f, vlat);
         end
         if (f == 129) begin
            n_chk++;
            if (ol !== '0) begin
               n_fail++;
               $display("FAIL ident_wrap_l: got %0d expected 0", ol);
            end
         end
         if (f == 65) begin
            n_chk++;
            if (orr !== '0) begin
               n_fail++;
               $display("FAIL ident_wrap_r: got %0d expected 0", orr);
            end
         end
         phl = (phl + 8) % SIZE;
         phr = (phr + 16) % SIZE;
         repeat (2) @(negedge clk_audio);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] ol, orr;
      logic [AW-1:0] pa_l, pa_r;
      int            k, vlat;
      bit            held;
      rom_mode = 0;
      @(negedge clk_audio);
      step_l      = 8;
      step_r      = 16;
      atten_l     = 0;
      atten_r     = 0;
      enable      = 1'b1;
      sample_tick = 1'b1;
      out_ready   = 1'b0;
      @(negedge clk_audio);
      sample_tick = 1'b0;
      k = 1;
      while (!out_valid && k < 16) begin
         @(negedge clk_audio);
         k++;
      end
      ol  = out_left;
      orr = out_right;
      n_chk++;
      if (ol !== DW'(phl) || orr !== DW'(phr) || k !== 4) begin
         n_fail++;
         $display("FAIL bp_first: got %0d,%0d lat %0d expected %0d,%0d lat 4",
                  ol, orr, k, phl, phr);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_audio);
         sample_tick = (i == 1);
         n_chk++;
         if (out_valid !== 1'b1 || out_left !== ol || out_right !== orr) begin
            n_fail++;
            $display("FAIL bp_hold c%0d: got v%b %h/%h expected v1 %h/%h",
                     i, out_valid, out_left, out_right, ol, orr);
         end
      end
      sample_tick = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk_audio);
      n_chk++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_overrun: got %b expected 1", overrun);
      end
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got %b expected 0", out_valid);
      end
      phl = (phl + 8) % SIZE;
      phr = (phr + 16) % SIZE;
      do_frame(8, 16, 0, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (pa_l !== AW'(phl) || pa_r !== AW'(phr)) begin
         n_fail++;
         $display("FAIL bp_next_addr: got %0d,%0d expected %0d,%0d",
                  pa_l, pa_r, phl, phr);
      end
      phl = (phl + 8) % SIZE;
      phr = (phr + 16) % SIZE;
   endtask

   task automatic test_atten();
      logic [DW-1:0] ol, orr;
      logic [AW-1:0] pa_l, pa_r;
      int            vlat;
      bit            held;
      rom_mode  = 1;
      rom_const = 16'h8000;
      do_frame(0, 0, 4, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (ol !== 16'hF800 || orr !== 16'h8000) begin
         n_fail++;
         $display("FAIL att_neg: got %h,%h expected f800,8000", ol, orr);
      end
      n_chk++;
      if (pa_l !== AW'(phl) || pa_r !== AW'(phr)) begin
         n_fail++;
         $display("FAIL att_step0_addr: got %0d,%0d expected %0d,%0d",
                  pa_l, pa_r, phl, phr);
      end
      rom_const = 16'h7FFF;
      do_frame(0, 0, 0, 15, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (ol !== 16'h7FFF || orr !== 16'h0000) begin
         n_fail++;
         $display("FAIL att_pos15: got %h,%h expected 7fff,0000", ol, orr);
      end
      do_frame(0, 0, 15, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (ol !== 16'h0000 || orr !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL att_pos0: got %h,%h expected 0000,7fff", ol, orr);
      end
      n_chk++;
      if (pa_l !== AW'(phl) || pa_r !== AW'(phr)) begin
         n_fail++;
         $display("FAIL att_step0_hold: got %0d,%0d expected %0d,%0d",
                  pa_l, pa_r, phl, phr);
      end
   endtask

   task automatic test_midframe();
      logic [DW-1:0] ol, orr;
      logic [AW-1:0] pa_l, pa_r;
      int            vlat;
      bit            held;
      do_reset();
      rom_mode = 0;
      @(negedge clk_audio);
      step_l      = 8;
      step_r      = 5;
      atten_l     = 0;
      atten_r     = 0;
      enable      = 1'b1;
      sample_tick = 1'b1;
      out_ready   = 1'b1;
      @(negedge clk_audio);
      sample_tick = 1'b0;
      @(negedge clk_audio);
      step_l = 3;
      @(negedge clk_audio);
      enable = 1'b0;
      @(negedge clk_audio);
      n_chk++;
      if (out_valid !== 1'b1 || out_left !== 16'd0 || out_right !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_present: got v%b %0d,%0d expected v1 0,0",
                  out_valid, out_left, out_right);
      end
      @(negedge clk_audio);
      phl = 8;
      phr = 5;
      sample_tick = 1'b1;
      @(negedge clk_audio);
      sample_tick = 1'b0;
      n_chk++;
      if (rom_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_disabled_tick: got rom_en %b expected 0", rom_en);
      end
      repeat (4) @(negedge clk_audio);
      n_chk++;
      if (out_valid !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_no_frame: got v%b ovr%b expected v0 ovr0",
                  out_valid, overrun);
      end
      do_frame(3, 5, 0, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (pa_l !== 10'd8 || ol !== 16'd8 || orr !== 16'd5) begin
         n_fail++;
         $display("FAIL mid_step_old: got %0d,%0d,%0d expected 8,8,5",
                  pa_l, ol, orr);
      end
      do_frame(3, 5, 0, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (pa_l !== 10'd11 || ol !== 16'd11 || orr !== 16'd10) begin
         n_fail++;
         $display("FAIL mid_step_new: got %0d,%0d,%0d expected 11,11,10",
                  pa_l, ol, orr);
      end
   endtask

   task automatic test_reset_midframe();
      logic [DW-1:0] ol, orr;
      logic [AW-1:0] pa_l, pa_r;
      int            vlat;
      bit            held;
      rom_mode = 0;
      @(negedge clk_audio);
      step_l      = 7;
      step_r      = 9;
      enable      = 1'b1;
      sample_tick = 1'b1;
      @(negedge clk_audio);
      sample_tick = 1'b0;
      @(negedge clk_audio);
      reset = 1'b1;
      @(negedge clk_audio);
      reset = 1'b0;
      n_chk++;
      if (rom_en !== 1'b0 || rom_addr !== '0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: got en%b a%0d v%b expected en0 a0 v0",
                  rom_en, rom_addr, out_valid);
      end
      repeat (3) @(negedge clk_audio);
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_abandon: got v%b expected 0", out_valid);
      end
      phl = 0;
      phr = 0;
      do_frame(5, 6, 0, 0, 0, ol, orr, vlat, pa_l, pa_r, held);
      n_chk++;
      if (pa_l !== '0 || pa_r !== '0 || ol !== '0 || orr !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_phase: got %0d,%0d expected 0,0", pa_l, pa_r);
      end
      phl = 5;
      phr = 6;
   endtask

   task automatic test_random();
      logic [DW-1:0] ol, orr, el, er;
      logic [AW-1:0] pa_l, pa_r, sl, sr;
      logic [3:0]    al, ar;
      int            vlat, stall;
      bit            held;
      do_reset();
      rom_mode = 2;
      for (int f = 0; f < 40; f++) begin
         sl    = AW'($urandom);
         sr    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         al    = 4'($urandom);
         ar    = 4'($urandom);
         stall = $urandom_range(0, 3);
         el    = atten_fn(rom_fn(phl), int'(al));
         er    = atten_fn(rom_fn(phr), int'(ar));
         do_frame(sl, sr, al, ar, stall, ol, orr, vlat, pa_l, pa_r, held);
         n_chk++;
         if (ol !== el || orr !== er) begin
            n_fail++;
            $display("FAIL rnd_pair f%0d: got %h,%h expected %h,%h",
                     f, ol, orr, el, er);
         end
         n_chk++;
         if (pa_l !== AW'(phl) || pa_r !== AW'(phr)) begin
            n_fail++;
            $display("FAIL rnd_addr f%0d: got %0d,%0d expected %0d,%0d",
                     f, pa_l, pa_r, phl, phr);
         end
         n_chk++;
         if (vlat !== 4 || !held) begin
            n_fail++;
            $display("FAIL rnd_timing f%0d: got lat %0d held %b expected 4 1",
                     f, vlat, held);
         end
         phl = (phl + int'(sl)) % SIZE;
         phr = (phr + int'(sr)) % SIZE;
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            enable      = 1'b0;
            sample_tick = 1'($urandom);
            @(negedge clk_audio);
         end
         sample_tick = 1'b0;
      end
      n_chk++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL rnd_overrun: got %b expected 0", overrun);
      end
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      sample_tick = 1'b0;
      out_ready   = 1'b1;
      step_l      = '0;
      step_r      = '0;
      atten_l     = '0;
      atten_r     = '0;
      rom_mode    = 0;
      rom_const   = '0;
      phl         = 0;
      phr         = 0;
      test_reset();
      test_identity();
      test_backpressure();
      test_atten();
      test_midframe();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
